// File: rtl/pp_bpred_pkg.sv
// Shared types, defaults and helper functions for the pp_bpred branch target buffer.
// Optional statistics counters are enabled by defining PP_BPRED_STATS_EN.
package pp_bpred_pkg;

  localparam int PC_WIDTH_DEF  = 30;
  localparam int ENTRIES_DEF   = 64;
  localparam int TAG_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counters are carried in 32-bit containers so one helper serves any CNT_WIDTH.
  function automatic logic [31:0] cnt_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] cnt_inc(input logic [31:0] c, input int w);
    return (c >= cnt_max(w)) ? cnt_max(w) : (c + 32'd1);
  endfunction

  function automatic logic [31:0] cnt_dec(input logic [31:0] c);
    return (c == 32'd0) ? 32'd0 : (c - 32'd1);
  endfunction

  function automatic logic [31:0] cnt_weak_taken(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/pp_bpred_stats.sv
// Optional lookup/update/mispredict counters for pp_bpred; only instantiated
// when PP_BPRED_STATS_EN is defined.
module pp_bpred_stats (
  input  logic        clk,
  input  logic        rstb,
  input  logic        flush,
  input  logic        upd_valid,
  input  logic        mispredict,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  logic [31:0] r_lookups;
  logic [31:0] r_updates;
  logic [31:0] r_mispredicts;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_lookups     <= '0;
      r_updates     <= '0;
      r_mispredicts <= '0;
    end else if (flush) begin
      r_lookups     <= '0;
      r_updates     <= '0;
      r_mispredicts <= '0;
    end else begin
      r_lookups <= r_lookups + 32'd1;
      if (upd_valid) begin
        r_updates <= r_updates + 32'd1;
        if (mispredict) r_mispredicts <= r_mispredicts + 32'd1;
      end
    end
  end

  assign stat_lookups     = r_lookups;
  assign stat_updates     = r_updates;
  assign stat_mispredicts = r_mispredicts;

endmodule

// File: rtl/pp_bpred.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Define PP_BPRED_STATS_EN to add the stat_* counter outputs.
module pp_bpred
  import pp_bpred_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int ENTRIES   = ENTRIES_DEF,
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                flush
`ifdef PP_BPRED_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int IDX_W  = clog2(ENTRIES);
  localparam int TAG_HI = IDX_W + TAG_WIDTH - 1;

  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_WIDTH-1:0] r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0]  r_target [ENTRIES];
  logic [CNT_WIDTH-1:0] r_cnt    [ENTRIES];

  logic [IDX_W-1:0]     w_lk_idx;
  logic [TAG_WIDTH-1:0] w_lk_tag;
  logic                 w_lk_hit;
  logic [IDX_W-1:0]     w_upd_idx;
  logic [TAG_WIDTH-1:0] w_upd_tag;
  logic                 w_upd_hit;
  logic                 w_alloc;
  logic [31:0]          w_cnt_cur32;
  logic [31:0]          w_cnt_inc32;
  logic [31:0]          w_cnt_dec32;
  logic [31:0]          w_weak32;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH-1:0] w_cnt_weak;
  logic                 w_unused;

  assign w_lk_idx = lookup_pc[IDX_W-1:0];
  assign w_lk_tag = lookup_pc[TAG_HI:IDX_W];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  // Lookup reads pre-update contents; there is deliberately no bypass from upd_*.
  assign pred_hit    = w_lk_hit;
  assign pred_taken  = w_lk_hit && r_cnt[w_lk_idx][CNT_WIDTH-1];
  assign pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;

  assign w_upd_idx = upd_pc[IDX_W-1:0];
  assign w_upd_tag = upd_pc[TAG_HI:IDX_W];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_alloc   = upd_valid && upd_taken && !w_upd_hit;

  assign w_cnt_cur32 = 32'(r_cnt[w_upd_idx]);
  assign w_cnt_inc32 = cnt_inc(w_cnt_cur32, CNT_WIDTH);
  assign w_cnt_dec32 = cnt_dec(w_cnt_cur32);
  assign w_weak32    = cnt_weak_taken(CNT_WIDTH);
  assign w_cnt_next  = upd_taken ? w_cnt_inc32[CNT_WIDTH-1:0] : w_cnt_dec32[CNT_WIDTH-1:0];
  assign w_cnt_weak  = w_weak32[CNT_WIDTH-1:0];

  assign w_unused = ^{w_cnt_inc32, w_cnt_dec32, w_weak32, lookup_pc, upd_pc};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_alloc) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset so they can map onto RAM; r_valid gates them.
  always_ff @(posedge clk) begin
    if (upd_valid && !flush) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= w_cnt_next;
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_cnt[w_upd_idx]    <= w_cnt_weak;
      end
    end
  end

`ifdef PP_BPRED_STATS_EN
  logic w_upd_pred;
  logic w_mispredict;

  assign w_upd_pred   = w_upd_hit && r_cnt[w_upd_idx][CNT_WIDTH-1];
  assign w_mispredict = (w_upd_pred != upd_taken) ||
                        (w_upd_pred && upd_taken && (r_target[w_upd_idx] != upd_target));

  pp_bpred_stats u_stats (
    .clk              (clk),
    .rstb             (rstb),
    .flush            (flush),
    .upd_valid        (upd_valid),
    .mispredict       (w_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );
`endif

endmodule
